// File: rtl/uk101_video_timing_if.sv
// rtl/uk101_video_timing_if.sv - raster timing bundle between the UK101 timing generator and its consumers
interface uk101_video_timing_if #(
  parameter int HW = 10,
  parameter int VW = 9
);
  logic          mode_sel;
  logic          ce_pix;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hblank;
  logic          vblank;
  logic          hsync;
  logic          vsync;
  logic          frame_start;
  logic          mode_active;

  modport master (
    input  mode_sel,
    output ce_pix, hcount, vcount, hblank, vblank,
    output hsync, vsync, frame_start, mode_active
  );

  modport slave (
    output mode_sel,
    input  ce_pix, hcount, vcount, hblank, vblank,
    input  hsync, vsync, frame_start, mode_active
  );
endinterface

// File: rtl/uk101_video_timing.sv
// rtl/uk101_video_timing.sv - UK101 raster timing generator with two geometries switched at frame wrap
module uk101_video_timing #(
  parameter int CE_DIV  = 6,
  parameter int HW      = 10,
  parameter int VW      = 9,
  parameter int H_ACT0  = 384,
  parameter int H_FP0   = 40,
  parameter int H_SYNC0 = 40,
  parameter int H_BP0   = 68,
  parameter int V_ACT0  = 256,
  parameter int V_FP0   = 24,
  parameter int V_SYNC0 = 4,
  parameter int V_BP0   = 28,
  parameter int H_ACT1  = 448,
  parameter int H_FP1   = 24,
  parameter int H_SYNC1 = 40,
  parameter int H_BP1   = 20,
  parameter int V_ACT1  = 240,
  parameter int V_FP1   = 32,
  parameter int V_SYNC1 = 4,
  parameter int V_BP1   = 36,
  parameter bit SYNC_POL = 1'b0
) (
  input logic                  clk_sys,
  input logic                  reset,
  uk101_video_timing_if.master vid
);

  localparam int H_TOT0 = H_ACT0 + H_FP0 + H_SYNC0 + H_BP0;
  localparam int V_TOT0 = V_ACT0 + V_FP0 + V_SYNC0 + V_BP0;
  localparam int H_TOT1 = H_ACT1 + H_FP1 + H_SYNC1 + H_BP1;
  localparam int V_TOT1 = V_ACT1 + V_FP1 + V_SYNC1 + V_BP1;
  localparam int DW     = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
    $error("uk101_video_timing: CE_DIV must be in 2..16");
  end
  if (H_ACT0 < 1 || H_FP0 < 1 || H_SYNC0 < 1 || H_BP0 < 1 ||
      H_ACT1 < 1 || H_FP1 < 1 || H_SYNC1 < 1 || H_BP1 < 1) begin : g_bad_h_region
    $error("uk101_video_timing: every horizontal region must be at least 1");
  end
  if (V_ACT0 < 1 || V_FP0 < 1 || V_SYNC0 < 1 || V_BP0 < 1 ||
      V_ACT1 < 1 || V_FP1 < 1 || V_SYNC1 < 1 || V_BP1 < 1) begin : g_bad_v_region
    $error("uk101_video_timing: every vertical region must be at least 1");
  end
  if (H_TOT0 > (1 << HW) || H_TOT1 > (1 << HW)) begin : g_bad_h_total
    $error("uk101_video_timing: horizontal total does not fit in HW bits");
  end
  if (V_TOT0 > (1 << VW) || V_TOT1 > (1 << VW)) begin : g_bad_v_total
    $error("uk101_video_timing: vertical total does not fit in VW bits");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

  // Region edges: last count, first blanked count, sync start, first count past sync.
  localparam logic [HW-1:0] H_LAST0 = HW'(H_TOT0 - 1);
  localparam logic [HW-1:0] H_A0    = HW'(H_ACT0);
  localparam logic [HW-1:0] H_SS0   = HW'(H_ACT0 + H_FP0);
  localparam logic [HW-1:0] H_SE0   = HW'(H_ACT0 + H_FP0 + H_SYNC0);
  localparam logic [HW-1:0] H_LAST1 = HW'(H_TOT1 - 1);
  localparam logic [HW-1:0] H_A1    = HW'(H_ACT1);
  localparam logic [HW-1:0] H_SS1   = HW'(H_ACT1 + H_FP1);
  localparam logic [HW-1:0] H_SE1   = HW'(H_ACT1 + H_FP1 + H_SYNC1);
  localparam logic [VW-1:0] V_LAST0 = VW'(V_TOT0 - 1);
  localparam logic [VW-1:0] V_A0    = VW'(V_ACT0);
  localparam logic [VW-1:0] V_SS0   = VW'(V_ACT0 + V_FP0);
  localparam logic [VW-1:0] V_SE0   = VW'(V_ACT0 + V_FP0 + V_SYNC0);
  localparam logic [VW-1:0] V_LAST1 = VW'(V_TOT1 - 1);
  localparam logic [VW-1:0] V_A1    = VW'(V_ACT1);
  localparam logic [VW-1:0] V_SS1   = VW'(V_ACT1 + V_FP1);
  localparam logic [VW-1:0] V_SE1   = VW'(V_ACT1 + V_FP1 + V_SYNC1);

  logic [DW-1:0] div_q;
  logic          ce_q;
  logic          fs_q;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          hblank_q;
  logic          vblank_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          mode_q;
  logic          mode_meta_q;
  logic          mode_pend_q;

  logic [HW-1:0] h_last;
  logic [HW-1:0] h_nx;
  logic [HW-1:0] nx_h_act;
  logic [HW-1:0] nx_h_ss;
  logic [HW-1:0] nx_h_se;
  logic [VW-1:0] v_last;
  logic [VW-1:0] v_nx;
  logic [VW-1:0] nx_v_act;
  logic [VW-1:0] nx_v_ss;
  logic [VW-1:0] nx_v_se;
  logic          h_wrap;
  logic          v_wrap;
  logic          mode_nx;

  // Wrap points follow the geometry in use; region edges follow the geometry the next pixel belongs to.
  always_comb begin
    h_last   = mode_q ? H_LAST1 : H_LAST0;
    v_last   = mode_q ? V_LAST1 : V_LAST0;
    h_wrap   = (h_q == h_last);
    v_wrap   = (v_q == v_last);
    h_nx     = h_wrap ? '0 : h_q + HW'(1);
    v_nx     = v_q;
    if (h_wrap) begin
      v_nx = v_wrap ? '0 : v_q + VW'(1);
    end
    mode_nx  = (h_wrap && v_wrap) ? mode_pend_q : mode_q;
    nx_h_act = mode_nx ? H_A1  : H_A0;
    nx_h_ss  = mode_nx ? H_SS1 : H_SS0;
    nx_h_se  = mode_nx ? H_SE1 : H_SE0;
    nx_v_act = mode_nx ? V_A1  : V_A0;
    nx_v_ss  = mode_nx ? V_SS1 : V_SS0;
    nx_v_se  = mode_nx ? V_SE1 : V_SE0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      ce_q        <= 1'b0;
      fs_q        <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      hsync_q     <= SYNC_POL;
      vsync_q     <= SYNC_POL;
      mode_q      <= 1'b0;
      mode_meta_q <= 1'b0;
      mode_pend_q <= 1'b0;
    end else begin
      mode_meta_q <= vid.mode_sel;
      mode_pend_q <= mode_meta_q;

      // The position cannot move at a divider wrap, so frame_start sees the pixel shown during ce_pix.
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        ce_q  <= 1'b1;
        fs_q  <= (h_q == '0) && (v_q == '0);
      end else begin
        div_q <= div_q + DW'(1);
        ce_q  <= 1'b0;
        fs_q  <= 1'b0;
      end

      if (ce_q) begin
        h_q      <= h_nx;
        v_q      <= v_nx;
        mode_q   <= mode_nx;
        hblank_q <= (h_nx >= nx_h_act);
        vblank_q <= (v_nx >= nx_v_act);
        hsync_q  <= ((h_nx >= nx_h_ss) && (h_nx < nx_h_se)) ^ SYNC_POL;
        vsync_q  <= ((v_nx >= nx_v_ss) && (v_nx < nx_v_se)) ^ SYNC_POL;
      end
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.hcount      = h_q;
  assign vid.vcount      = v_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.frame_start = fs_q;
  assign vid.mode_active = mode_q;

endmodule

// File: tb/tb_uk101_video_timing.sv
// tb/tb_uk101_video_timing.sv - scoreboard bench for uk101_video_timing on two scaled-down geometries
module tb_uk101_video_timing;

  localparam int CE_A = 2;
  localparam int CE_B = 4;
  localparam int HW   = 4;
  localparam int VW   = 4;
  localparam int H_ACT[2]  = '{8, 10};
  localparam int H_FP[2]   = '{2, 2};
  localparam int H_SYNC[2] = '{2, 2};
  localparam int H_BP[2]   = '{2, 2};
  localparam int V_ACT[2]  = '{6, 5};
  localparam int V_FP[2]   = '{1, 2};
  localparam int V_SYNC[2] = '{1, 1};
  localparam int V_BP[2]   = '{2, 3};

  typedef struct packed {
    logic          mode;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          hb;
    logic          vb;
    logic          hs;
    logic          vs;
    logic          fs;
  } pix_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  uk101_video_timing_if #(.HW(HW), .VW(VW)) vif_a ();
  uk101_video_timing_if #(.HW(HW), .VW(VW)) vif_b ();

  uk101_video_timing #(
    .CE_DIV(CE_A), .HW(HW), .VW(VW),
    .H_ACT0(H_ACT[0]), .H_FP0(H_FP[0]), .H_SYNC0(H_SYNC[0]), .H_BP0(H_BP[0]),
    .V_ACT0(V_ACT[0]), .V_FP0(V_FP[0]), .V_SYNC0(V_SYNC[0]), .V_BP0(V_BP[0]),
    .H_ACT1(H_ACT[1]), .H_FP1(H_FP[1]), .H_SYNC1(H_SYNC[1]), .H_BP1(H_BP[1]),
    .V_ACT1(V_ACT[1]), .V_FP1(V_FP[1]), .V_SYNC1(V_SYNC[1]), .V_BP1(V_BP[1]),
    .SYNC_POL(1'b0)
  ) u_dut_a (
    .clk_sys(clk_sys),
    .reset  (reset),
    .vid    (vif_a)
  );

  uk101_video_timing #(
    .CE_DIV(CE_B), .HW(HW), .VW(VW),
    .H_ACT0(H_ACT[0]), .H_FP0(H_FP[0]), .H_SYNC0(H_SYNC[0]), .H_BP0(H_BP[0]),
    .V_ACT0(V_ACT[0]), .V_FP0(V_FP[0]), .V_SYNC0(V_SYNC[0]), .V_BP0(V_BP[0]),
    .H_ACT1(H_ACT[1]), .H_FP1(H_FP[1]), .H_SYNC1(H_SYNC[1]), .H_BP1(H_BP[1]),
    .V_ACT1(V_ACT[1]), .V_FP1(V_FP[1]), .V_SYNC1(V_SYNC[1]), .V_BP1(V_BP[1]),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk_sys(clk_sys),
    .reset  (reset),
    .vid    (vif_b)
  );

  int   tests = 0;
  int   fails = 0;
  pix_t exp_q[$];
  int   ph;
  int   pv;
  bit   pm;
  bit   pm_next;

  function automatic int htot(bit m);
    return H_ACT[m] + H_FP[m] + H_SYNC[m] + H_BP[m];
  endfunction

  function automatic int vtot(bit m);
    return V_ACT[m] + V_FP[m] + V_SYNC[m] + V_BP[m];
  endfunction

  function automatic pix_t exp_pix(bit m, int h, int v, bit pol);
    pix_t p;
    p.mode = m;
    p.h    = HW'(h);
    p.v    = VW'(v);
    p.hb   = (h >= H_ACT[m]);
    p.vb   = (v >= V_ACT[m]);
    p.hs   = ((h >= H_ACT[m] + H_FP[m]) && (h < H_ACT[m] + H_FP[m] + H_SYNC[m])) ^ pol;
    p.vs   = ((v >= V_ACT[m] + V_FP[m]) && (v < V_ACT[m] + V_FP[m] + V_SYNC[m])) ^ pol;
    p.fs   = (h == 0) && (v == 0);
    return p;
  endfunction

  function automatic pix_t observe(bit sel);
    pix_t p;
    if (sel) p = {vif_b.mode_active, vif_b.hcount, vif_b.vcount, vif_b.hblank,
                  vif_b.vblank, vif_b.hsync, vif_b.vsync, vif_b.frame_start};
    else     p = {vif_a.mode_active, vif_a.hcount, vif_a.vcount, vif_a.hblank,
                  vif_a.vblank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
    return p;
  endfunction

  task automatic model_reset();
    ph = 0;
    pv = 0;
    pm = 1'b0;
    pm_next = 1'b0;
    exp_q.delete();
  endtask

  // Expected pixels in display order; a pending geometry takes over after the last pixel of a frame.
  task automatic push_pix(input int n, input bit pol);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_pix(pm, ph, pv, pol));
      ph++;
      if (ph == htot(pm)) begin
        ph = 0;
        pv++;
        if (pv == vtot(pm)) begin
          pv = 0;
          pm = pm_next;
        end
      end
    end
  endtask

  task automatic wait_ce(input bit sel, output int waited);
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (waited < 64 && !(sel ? vif_b.ce_pix : vif_a.ce_pix));
  endtask

  task automatic test_reset();
    pix_t o;
    repeat (3) @(negedge clk_sys);
    o = observe(0);
    tests++;
    if (o !== {1'b0, 4'd0, 4'd0, 5'b00000} || vif_a.ce_pix !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: got %h ce=%b, expected %h ce=0", o, vif_a.ce_pix, {1'b0, 4'd0, 4'd0, 5'b00000});
    end
    o = observe(1);
    tests++;
    if (o !== {1'b0, 4'd0, 4'd0, 5'b00110} || vif_b.ce_pix !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: got %h ce=%b, expected %h ce=0", o, vif_b.ce_pix, {1'b0, 4'd0, 4'd0, 5'b00110});
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_frame_mode0();
    pix_t e;
    pix_t o;
    int   w;
    push_pix(htot(0) * vtot(0) + 1, 1'b0);
    while (exp_q.size() > 0) begin
      wait_ce(0, w);
      e = exp_q.pop_front();
      o = observe(0);
      tests++;
      if (w != CE_A || o !== e) begin
        fails++;
        $display("FAIL frame0 h=%0d v=%0d: got %h after %0d clks, expected %h after %0d clks", e.h, e.v, o, w, e, CE_A);
      end
    end
  endtask

  task automatic test_mode_switch();
    pix_t e;
    pix_t o;
    int   w;
    for (int ln = 0; ln < 33; ln++) begin
      case (ln)
        3:  begin vif_a.mode_sel = 1'b1; pm_next = 1'b1; end
        12: vif_a.mode_sel = 1'b0;
        13: vif_a.mode_sel = 1'b1;
        24: begin vif_a.mode_sel = 1'b0; pm_next = 1'b0; end
        default: ;
      endcase
      push_pix(htot(pm) - ph, 1'b0);
      while (exp_q.size() > 0) begin
        wait_ce(0, w);
        e = exp_q.pop_front();
        o = observe(0);
        tests++;
        if (w != CE_A || o !== e) begin
          fails++;
          $display("FAIL mode_switch line %0d h=%0d v=%0d: got %h after %0d clks, expected %h after %0d clks", ln, e.h, e.v, o, w, e, CE_A);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    pix_t e;
    pix_t o;
    int   w;
    push_pix(htot(pm) * 3 + 7, 1'b0);
    while (exp_q.size() > 0) begin
      wait_ce(0, w);
      e = exp_q.pop_front();
      o = observe(0);
      tests++;
      if (w != CE_A || o !== e) begin
        fails++;
        $display("FAIL mid_reset_run h=%0d v=%0d: got %h after %0d clks, expected %h after %0d clks", e.h, e.v, o, w, e, CE_A);
      end
    end
    #2 reset = 1'b1;
    #1;
    o = observe(0);
    tests++;
    if (o !== {1'b0, 4'd0, 4'd0, 5'b00000} || vif_a.ce_pix !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: got %h ce=%b, expected %h ce=0", o, vif_a.ce_pix, {1'b0, 4'd0, 4'd0, 5'b00000});
    end
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    push_pix(htot(0) + 1, 1'b0);
    while (exp_q.size() > 0) begin
      wait_ce(0, w);
      e = exp_q.pop_front();
      o = observe(0);
      tests++;
      if (w != CE_A || o !== e) begin
        fails++;
        $display("FAIL mid_reset_restart h=%0d v=%0d: got %h after %0d clks, expected %h after %0d clks", e.h, e.v, o, w, e, CE_A);
      end
    end
  endtask

  task automatic test_polarity();
    pix_t e;
    pix_t o;
    int   w;
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    push_pix(htot(0) * vtot(0) + 1, 1'b1);
    while (exp_q.size() > 0) begin
      wait_ce(1, w);
      e = exp_q.pop_front();
      o = observe(1);
      tests++;
      if (w != CE_B || o !== e) begin
        fails++;
        $display("FAIL polarity h=%0d v=%0d: got %h after %0d clks, expected %h after %0d clks", e.h, e.v, o, w, e, CE_B);
      end
    end
  endtask

  initial begin
    vif_a.mode_sel = 1'b0;
    vif_b.mode_sel = 1'b0;
    test_reset();
    test_frame_mode0();
    test_mode_switch();
    test_mid_reset();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uk101_video_timing.md
Name: uk101_video_timing

Overview:
- Parametrised raster timing generator for the UK101 core.
- Replaces the fixed divide-by-6 pixel clock-enable counter in the emu top level.
- Produces the pixel clock enable, h/v counters, blanking, sync and frame strobe consumed by the character generator and the video mixer.
- Holds two run-time-selectable geometries, 64x32 and 48x16 character modes; a mode change is deferred to the frame boundary.

Parameters:
CE_DIV, 6, system clocks per pixel (2..16); 50 MHz/6 = 8.33 MHz
HW, 10, hcount width
VW, 9, vcount width
H_ACT0/H_FP0/H_SYNC0/H_BP0, 384/40/40/68, mode 0 horizontal regions in pixels (total 532)
V_ACT0/V_FP0/V_SYNC0/V_BP0, 256/24/4/28, mode 0 vertical regions in lines (total 312)
H_ACT1/H_FP1/H_SYNC1/H_BP1, 448/24/40/20, mode 1 horizontal regions (total 532)
V_ACT1/V_FP1/V_SYNC1/V_BP1, 240/32/4/36, mode 1 vertical regions (total 312)
SYNC_POL, 0, 0 = syncs active-high, 1 = active-low

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
mode_sel  in  1  requested geometry (0 = mode 0, 1 = mode 1)
ce_pix  out  1  one-clk pixel enable, every CE_DIV clocks
hcount  out  HW  current pixel within line
vcount  out  VW  current line within frame
hblank  out  1  high outside horizontal active region
vblank  out  1  high outside vertical active region
hsync  out  1  horizontal sync (polarity per SYNC_POL)
vsync  out  1  vertical sync (polarity per SYNC_POL)
frame_start  out  1  one-clk pulse at pixel (0,0)
mode_active  out  1  geometry currently in use

Behaviour:
- Reset values (while reset high, asynchronous):
  - divider counter = 0, ce_pix = 0, hcount = 0, vcount = 0;
  - hblank = 0, vblank = 0, frame_start = 0;
  - hsync and vsync inactive (SYNC_POL);
  - mode_active = 0, pending mode = 0.
- Divider:
  - counts 0..CE_DIV-1 and wraps;
  - ce_pix is registered, high for exactly one clk when the divider wraps;
  - first ce_pix is high in the cycle after the CE_DIV-th rising edge following reset release;
  - period is exactly CE_DIV clks, duty 1/CE_DIV.
- Counters and outputs update only on the clk edge at which ce_pix is high.
  - Every pixel value is therefore stable for CE_DIV clks and is sampled by consumers while ce_pix is high.
  - All outputs are registered and mutually aligned; no combinational path from inputs to outputs.
- Region bounds (mode_active geometry; H_TOT = H_ACT+H_FP+H_SYNC+H_BP):
  - hcount runs 0..H_TOT-1 and wraps to 0.
  - hblank = hcount >= H_ACT.
  - hsync active for H_ACT+H_FP <= hcount < H_ACT+H_FP+H_SYNC.
  - vcount increments when hcount wraps; vcount runs 0..V_TOT-1 and wraps to 0.
  - vblank and vsync are defined analogously on vcount; vblank/vsync change only at hcount = 0.
  - All comparisons use HW/VW-bit unsigned arithmetic.
  - Each region parameter must be >= 1, with H_TOT <= 2^HW and V_TOT <= 2^VW; elaboration-time assertion otherwise.
- frame_start is high for the one clk where ce_pix is high and hcount = 0, vcount = 0.
- Mode switch:
  - mode_sel is double-flopped into the pending register every clk.
  - At the frame-wrap update (hcount = H_TOT-1 and vcount = V_TOT-1 on ce), mode_active <= pending.
  - The new geometry applies from that same update, so (0,0) of the next frame already uses it.
  - Toggling mode_sel mid-frame has no effect on the current frame.
  - A toggle and return before the frame boundary causes no switch.
  - Mode change never produces a short line or a short frame.
- Reset mid-frame: counters and outputs return to reset values immediately; the divider restarts at 0.
- No external freeze or stall; the generator free-runs.

Test Plan:
1. Defaults; release reset at t0 -> first ce_pix in the cycle after the 6th edge, then every 6 clks. hcount 0 -> 1 on the first ce. hblank, hsync and frame_start stay 0 until reached.
2. Mode 0 line -> hblank rises at hcount 384, hsync high for hcount 424..463, hcount wraps 531 -> 0. Line length = 532 × 6 = 3192 clks.
3. Mode 0 frame -> vblank at vcount 256..311, vsync for vcount 280..283. frame_start every 312 × 3192 = 995904 clks.
4. Set mode_sel = 1 at vcount 100 -> mode_active stays 0 until the wrap from (531,311). Next frame: hblank at 448, vblank at 240, hsync 472..511. Pulse mode_sel 1 -> 0 within one frame -> no switch.
5. Assert reset for 3 clks at hcount 200, vcount 150 -> all outputs reset asynchronously. After release, timing matches scenario 1.
6. SYNC_POL = 1, CE_DIV = 4 -> hsync/vsync low only inside sync windows, ce_pix period 4 clks, region positions unchanged.
